// File: rtl/quad_enc_gen_if.sv
// Command and waveform bundle between a step commander and the quadrature
// encoder emulator.
interface quad_enc_gen_if #(
    parameter int CNT_W = 8,
    parameter int POS_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic             stop;
    logic             enc_a;
    logic             enc_b;
    logic             busy;
    logic             done;
    logic [POS_W-1:0] position;

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, stop,
        input  cmd_ready, enc_a, enc_b, busy, done, position
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, stop,
        output cmd_ready, enc_a, enc_b, busy, done, position
    );
endinterface

// File: rtl/quad_enc_gen.sv
// Quadrature encoder emulator: turns step commands into a clean A/B waveform
// and tracks the count a working decoder should report.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | A/B parked at 00, cmd_ready high, waiting for a command
// ST_RUN  | emitting quadrature steps, one A/B transition per timer expiry
module quad_enc_gen #(
    parameter int PHASE_CYCLES = 1000,
    parameter int CNT_W        = 8,
    parameter int POS_W        = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    quad_enc_gen_if.slave bus
);
    localparam int            TW         = $clog2(PHASE_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(PHASE_CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             dir_q, dir_d;
    logic             stop_pend_q, stop_pend_d;
    logic             enc_a_q, enc_a_d;
    logic             enc_b_q, enc_b_d;
    logic             done_q, done_d;
    logic [POS_W-1:0] pos_q, pos_d;

    // Line state {A,B} for a given index within one quadrature step.
    function automatic logic [1:0] ab_of(input logic [1:0] idx, input logic fwd);
        logic [1:0] ab;
        case (idx)
            2'd0:    ab = 2'b00;
            2'd1:    ab = fwd ? 2'b10 : 2'b01;
            2'd2:    ab = 2'b11;
            default: ab = fwd ? 2'b01 : 2'b10;
        endcase
        return ab;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            idx_q       <= '0;
            remain_q    <= '0;
            dir_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            enc_a_q     <= 1'b0;
            enc_b_q     <= 1'b0;
            done_q      <= 1'b0;
            pos_q       <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            remain_q    <= remain_d;
            dir_q       <= dir_d;
            stop_pend_q <= stop_pend_d;
            enc_a_q     <= enc_a_d;
            enc_b_q     <= enc_b_d;
            done_q      <= done_d;
            pos_q       <= pos_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        remain_d    = remain_q;
        dir_d       = dir_q;
        stop_pend_d = stop_pend_q;
        enc_a_d     = enc_a_q;
        enc_b_d     = enc_b_q;
        done_d      = 1'b0;
        pos_d       = pos_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    dir_d       = bus.cmd_dir;
                    remain_d    = bus.cmd_steps;
                    stop_pend_d = 1'b0;
                    idx_d       = 2'd0;
                    timer_d     = TIMER_LOAD;
                    if (bus.cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                stop_pend_d = stop_pend_q | bus.stop;
                if (timer_q == '0) begin
                    timer_d            = TIMER_LOAD;
                    idx_d              = idx_q + 2'd1;
                    {enc_a_d, enc_b_d} = ab_of(idx_d, dir_q);
                    // Returning to 00 closes a step; only here may we stop.
                    if (idx_q == 2'd3) begin
                        remain_d = remain_q - CNT_W'(1);
                        pos_d    = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                        if (remain_q == CNT_W'(1) || stop_pend_q || bus.stop) begin
                            state_d     = ST_IDLE;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.enc_a     = enc_a_q;
    assign bus.enc_b     = enc_b_q;
    assign bus.done      = done_q;
    assign bus.position  = pos_q;
endmodule

// File: tb/tb_quad_enc_gen.sv
// Directed plus randomized bench for quad_enc_gen against a per-cycle
// arithmetic model of the expected waveform, position and handshake.
module tb_quad_enc_gen;
    localparam int P     = 4;
    localparam int CNT_W = 8;
    localparam int POS_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [POS_W-1:0] pos_m = '0;

    quad_enc_gen_if #(.CNT_W(CNT_W), .POS_W(POS_W)) bus_if ();

    quad_enc_gen #(.PHASE_CYCLES(P), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_ab(input bit fwd, input int n);
        logic [1:0] fseq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
        logic [1:0] rseq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        return fwd ? fseq[n % 4] : rseq[n % 4];
    endfunction

    task automatic rst_seq();
        @(negedge clk);
        rst_n               = 1'b0;
        bus_if.cmd_valid    = 1'b0;
        bus_if.cmd_dir      = 1'b0;
        bus_if.cmd_steps    = '0;
        bus_if.stop         = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pos_m = '0;
        chk("rst_ab",    {30'd0, bus_if.enc_a, bus_if.enc_b}, 32'd0);
        chk("rst_ready", {31'd0, bus_if.cmd_ready}, 32'd1);
        chk("rst_busy",  {31'd0, bus_if.busy}, 32'd0);
        chk("rst_done",  {31'd0, bus_if.done}, 32'd0);
        chk("rst_pos",   {24'd0, bus_if.position}, 32'd0);
    endtask

    // Starts and ends at a falling edge. k counts rising edges after the accepting edge.
    task automatic run_cmd(input bit dir, input int steps, input int stop_k, input int abort_k,
                           input bit hold, input bit ndir, input int nsteps);
        int seff, last, n, c, limit;
        logic [POS_W-1:0] pos0, pexp;
        bit d_exp, b_exp;
        pos0                = pos_m;
        bus_if.cmd_valid    = 1'b1;
        bus_if.cmd_dir      = dir;
        bus_if.cmd_steps    = CNT_W'(steps);
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            bus_if.cmd_dir   = ndir;
            bus_if.cmd_steps = CNT_W'(nsteps);
        end else begin
            bus_if.cmd_valid = 1'b0;
        end
        seff = steps;
        if (stop_k >= 1 && stop_k <= 4 * P * steps)
            seff = (stop_k + 4 * P - 1) / (4 * P);
        last  = 4 * P * seff;
        limit = hold ? last : last + 1;
        for (int k = 0; ; k++) begin
            n = k / P;
            if (n > 4 * seff) n = 4 * seff;
            c     = n / 4;
            pexp  = dir ? pos0 + POS_W'(c) : pos0 - POS_W'(c);
            d_exp = (seff == 0) ? (k == 0) : (k == last);
            b_exp = (seff > 0) && (k < last);
            chk("ab",    {30'd0, bus_if.enc_a, bus_if.enc_b}, {30'd0, exp_ab(dir, n)});
            chk("pos",   {24'd0, bus_if.position}, {24'd0, pexp});
            chk("done",  {31'd0, bus_if.done}, {31'd0, d_exp});
            chk("busy",  {31'd0, bus_if.busy}, {31'd0, b_exp});
            chk("ready", {31'd0, bus_if.cmd_ready}, {31'd0, !b_exp});
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                chk("abort_ab",    {30'd0, bus_if.enc_a, bus_if.enc_b}, 32'd0);
                chk("abort_pos",   {24'd0, bus_if.position}, 32'd0);
                chk("abort_done",  {31'd0, bus_if.done}, 32'd0);
                chk("abort_ready", {31'd0, bus_if.cmd_ready}, 32'd1);
                bus_if.stop = 1'b0;
                repeat (2) @(negedge clk);
                chk("abort_done_hold", {31'd0, bus_if.done}, 32'd0);
                rst_n = 1'b1;
                @(negedge clk);
                pos_m = '0;
                return;
            end
            if (k == limit) break;
            bus_if.stop = (k + 1 == stop_k);
            @(negedge clk);
        end
        bus_if.stop = 1'b0;
        pos_m = dir ? pos0 + POS_W'(seff) : pos0 - POS_W'(seff);
    endtask

    initial begin
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_dir   = 1'b0;
        bus_if.cmd_steps = '0;
        bus_if.stop      = 1'b0;

        rst_seq();
        run_cmd(1'b1, 1, -1, -1, 1'b0, 1'b0, 0);
        chk("fwd1_pos", {24'd0, bus_if.position}, 32'd1);

        rst_seq();
        run_cmd(1'b0, 3, -1, -1, 1'b0, 1'b0, 0);
        chk("rev3_pos", {24'd0, bus_if.position}, 32'd253);

        rst_seq();
        run_cmd(1'b1, 255, -1, -1, 1'b0, 1'b0, 0);
        chk("wrap255_pos", {24'd0, bus_if.position}, 32'd255);
        run_cmd(1'b1, 1, -1, -1, 1'b0, 1'b0, 0);
        chk("wrap0_pos", {24'd0, bus_if.position}, 32'd0);
        run_cmd(1'b1, 0, -1, -1, 1'b0, 1'b0, 0);
        chk("zero_pos", {24'd0, bus_if.position}, 32'd0);

        // stop between the first and second transition of a 5-step command,
        // with the next command already held on the bus.
        run_cmd(1'b1, 5, P + 2, -1, 1'b1, 1'b0, 2);
        chk("stop_pos", {24'd0, bus_if.position}, 32'd1);
        run_cmd(1'b0, 2, -1, -1, 1'b0, 1'b0, 0);
        chk("held_pos", {24'd0, bus_if.position}, 32'd255);

        // Abort while the line sits at 11.
        run_cmd(1'b1, 3, -1, 2 * P + 1, 1'b0, 1'b0, 0);
        run_cmd(1'b1, 2, -1, -1, 1'b0, 1'b0, 0);
        chk("post_abort_pos", {24'd0, bus_if.position}, 32'd2);

        for (int i = 0; i < 10; i++) begin
            int s, sk;
            bit d;
            d  = 1'($urandom_range(0, 1));
            s  = int'($urandom_range(0, 4));
            sk = -1;
            if (s > 0 && $urandom_range(0, 2) == 0)
                sk = int'($urandom_range(1, 4 * P * s));
            run_cmd(d, s, sk, -1, 1'b0, 1'b0, 0);
        end
        chk("rand_final_pos", {24'd0, bus_if.position}, {24'd0, pos_m});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/quad_enc_gen.md
Name: quad_enc_gen

Overview:
- Quadrature encoder emulator: converts step commands into a debounce-clean two-phase A/B waveform.
- It is the driving end of the encoder interface. It feeds the enc*_a/enc*_b inputs of the RGB mixer channels in system-level benches and in on-chip self-test.
- It also tracks the position a correctly working decoder must report, so the checker can compare directly.

Parameters:
- PHASE_CYCLES, 1000, clock cycles between consecutive A/B transitions; legal range >= 2.
- CNT_W, 8, width of the step-count field in a command.
- POS_W, 8, width of the position tracker; wraps modulo 2^POS_W.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  generator can accept a command; high only in IDLE.
- cmd_dir  in  1  1 = forward/increment (A leads B), 0 = reverse (B leads A).
- cmd_steps  in  CNT_W  number of full quadrature cycles to emit.
- stop  in  1  single-cycle request to end the current command early.
- enc_a  out  1  quadrature phase A; driven directly from a flop.
- enc_b  out  1  quadrature phase B; driven directly from a flop.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a command finishes, whether it completed, was stopped, or had zero steps.
- position  out  POS_W  expected decoder count.

Behaviour:
- Reset (reset low, asynchronous):
  - State = IDLE; enc_a = enc_b = 0; cmd_ready = 1; busy = 0; done = 0; position = 0.
  - Phase timer, quadrature index and remaining-step count all clear.
- Reset asserted mid-command aborts immediately. There is no done pulse, and position returns to 0.
- Idle line state is A=0, B=0. One step is 4 transitions and always ends back at 00.
  - Forward sequence: 00 -> 10 -> 11 -> 01 -> 00.
  - Reverse sequence: 00 -> 01 -> 11 -> 10 -> 00.
- Exactly one of A/B changes per transition; no glitches.
- Handshake: a command is accepted on the rising edge where cmd_valid & cmd_ready.
  - cmd_dir and cmd_steps are latched on that edge.
  - cmd_ready drops in the following cycle.
  - cmd_valid while busy is ignored and not queued.
- Zero-step command: accepted, state stays IDLE, done pulses in the cycle after acceptance, no A/B activity, cmd_ready stays 1.
- States:
  - IDLE -> RUN on acceptance with cmd_steps != 0.
  - RUN -> IDLE when the remaining count reaches 0 at the end of a step, or at the end of a step with stop pending.
- RUN timing:
  - The phase timer counts 0..PHASE_CYCLES-1.
  - The first A/B transition occurs PHASE_CYCLES cycles after the accepting edge.
  - Each later transition follows PHASE_CYCLES cycles after the previous one.
  - One step therefore takes 4*PHASE_CYCLES cycles.
- On the 4th transition of a step (return to 00), in the same edge:
  - remaining decrements;
  - position changes by +1 (forward) or -1 (reverse), wrapping modulo 2^POS_W;
  - if remaining becomes 0 or stop is pending: state = IDLE, busy = 0, cmd_ready = 1, and done = 1 for exactly that one following cycle.
- A new command can be accepted in the first cycle cmd_ready is high.
- stop:
  - Sampled in RUN and held pending until the current step completes.
  - A/B is never left mid-cycle; the waveform always returns to 00.
  - Ignored in IDLE.
  - stop arriving on the same edge as the final step's completion gives a single normal completion with a single done pulse.
- position changes only at step completion, never mid-step.

Test Plan:
1. Reset: hold reset low 3 cycles, release -> enc_a = enc_b = 0, cmd_ready = 1, busy = 0, done = 0, position = 0.
2. PHASE_CYCLES=4, command fwd/1 accepted at edge T:
   - A/B = 10 at T+4, 11 at T+8, 01 at T+12, 00 at T+16;
   - position = 1 and done pulse at T+16; cmd_ready = 1 after.
3. Reverse 3 steps from position 0:
   - 12 transitions following the order 01, 11, 10, 00;
   - position reads 255, 254, 253 at successive step ends;
   - exactly one done pulse.
4. Wrap and zero-step:
   - 255 forward steps then 1 more -> position 255 then 0;
   - cmd_steps = 0 -> done pulse next cycle, no A/B edges, position unchanged.
5. stop during transition 2 of step 1 of a 5-step command:
   - step 1 completes, A/B = 00, position = 1, one done pulse;
   - a cmd_valid held high during RUN is not accepted until cmd_ready returns.
6. reset low mid-step (A/B = 11):
   - A/B = 00 and position = 0 immediately (asynchronous), no done pulse;
   - after release, a new command executes normally.
